water_level_controller: RTL and testbench

Actuator-side companion to the water flow monitor: accepts a fill-to-level or drain-to-level command, drives the fill valve and drain pump, and supplies the monitor's mode and restart. Closes the loop on the 10-bit water level sensor, using a settle/hysteresis check. Aborts on monitor flow error, on the overall timeout, or on an external abort. Sits between the wash-cycle sequencer (command side) and the valve/pump drivers plus the flow monitor.

---
 rtl/wlc_pkg.sv | 45 ++++
 rtl/wlc_down_timer.sv | 26 ++
 rtl/water_level_controller.sv | 188 ++++++++++++++++++
 tb/tb_water_level_controller.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wlc_pkg.sv
// Shared types, status codes and saturating level helpers for the water level controller.
package wlc_pkg;

  localparam int unsigned LEVEL_W  = 10;
  localparam int unsigned STATUS_W = 3;

  typedef logic [LEVEL_W-1:0] level_t;

  // Latched fill/drain command
  typedef struct packed {
    logic   drain;
    level_t target;
  } wlc_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FILL,
    ST_DRAIN,
    ST_SETTLE,
    ST_DONE,
    ST_FAULT
  } state_e;

  localparam logic [STATUS_W-1:0] STATUS_OK       = 3'd0;
  localparam logic [STATUS_W-1:0] STATUS_TIMEOUT  = 3'd1;
  localparam logic [STATUS_W-1:0] STATUS_FLOW_ERR = 3'd2;
  localparam logic [STATUS_W-1:0] STATUS_ABORTED  = 3'd3;
  localparam logic [STATUS_W-1:0] STATUS_LEAK     = 3'd4;

  // a - d, clamped at 0; evaluated one bit wider so the borrow is visible
  function automatic level_t sat_sub(input level_t a, input int unsigned d);
    logic [LEVEL_W:0] r;
    r = {1'b0, a} - (LEVEL_W+1)'(d);
    return r[LEVEL_W] ? '0 : r[LEVEL_W-1:0];
  endfunction

  // a + d, clamped at full scale; evaluated one bit wider so the carry is visible
  function automatic level_t sat_add(input level_t a, input int unsigned d);
    logic [LEVEL_W:0] r;
    r = {1'b0, a} + (LEVEL_W+1)'(d);
    return r[LEVEL_W] ? '1 : r[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/wlc_down_timer.sv
// Loadable down-counter. count holds the number of cycles remaining after
// the current one, so zero_c marks the last counted cycle.
// Ports: clk, reset (async, active-high), load/load_val, en, zero_c.
module wlc_down_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Load wins over enable; the counter parks at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  count <= '0;
    else if (load)              count <= load_val;
    else if (en && count != '0) count <= count - W'(1);
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/water_level_controller.sv
// Fill/drain-to-level controller: drives fill valve and drain pump, restarts
// and sets the mode of the flow monitor, settles with hysteresis, and aborts
// on abort / flow error / timeout.
// Ports: clk, reset (async, active-high); command cmd_valid/cmd_ready/
// cmd_drain/cmd_target; water_level_sensor, flow_error, abort, clear_fault;
// outputs fill_valve, drain_pump, mon_mode, mon_reset, busy, done, fault, status.
// Build option: define WLC_LEAK_DETECT_EN to fault with LEAK when the level
// drops below target - 2*HYST during a fill settle.
module water_level_controller
  import wlc_pkg::*;
#(
  parameter int unsigned HYST          = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MAX_CYCLES    = 4000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_drain,
  input  logic [LEVEL_W-1:0]  cmd_target,
  input  logic [LEVEL_W-1:0]  water_level_sensor,
  input  logic                flow_error,
  input  logic                abort,
  input  logic                clear_fault,
  output logic                fill_valve,
  output logic                drain_pump,
  output logic                mon_mode,
  output logic                mon_reset,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [STATUS_W-1:0] status
);

  localparam int unsigned TMO_W = $clog2(MAX_CYCLES + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  state_e        state, state_nxt;
  wlc_cmd_t      cmd_q;
  logic          from_start_q;
  logic          accept, active, has_fault;
  logic          level_met, settle_ok, leak_c;
  logic          tmo_zero_c, settle_zero_c, settle_load;
  logic          mon_mode_nxt;
  logic [STATUS_W-1:0] fault_code, status_nxt;
  level_t        lo, hi;

  assign lo = sat_sub(cmd_q.target, HYST);
  assign hi = sat_add(cmd_q.target, HYST);

  assign active      = (state == ST_START) || (state == ST_FILL) ||
                       (state == ST_DRAIN) || (state == ST_SETTLE);
  assign settle_load = (state_nxt == ST_SETTLE) && (state != ST_SETTLE);

  // Per-command timeout, not reloaded on settle re-entry
  wlc_down_timer #(.W(TMO_W)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (TMO_W'(MAX_CYCLES - 1)),
    .en       (active),
    .zero_c   (tmo_zero_c)
  );

  // Settle window length
  wlc_down_timer #(.W(SET_W)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (settle_load),
    .load_val (SET_W'(SETTLE_CYCLES - 1)),
    .en       (state == ST_SETTLE),
    .zero_c   (settle_zero_c)
  );

  // Level checks against the latched command
  always_comb begin
    level_met = cmd_q.drain ? (water_level_sensor <= cmd_q.target)
                            : (water_level_sensor >= cmd_q.target);
    settle_ok = cmd_q.drain ? (water_level_sensor <= hi)
                            : (water_level_sensor >= lo);
`ifdef WLC_LEAK_DETECT_EN
    leak_c = (state == ST_SETTLE) && !cmd_q.drain &&
             (water_level_sensor < sat_sub(cmd_q.target, 2 * HYST));
`else
    leak_c = 1'b0;
`endif
  end

  // Next state and next registered output values
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    has_fault    = 1'b0;
    fault_code   = STATUS_OK;
    status_nxt   = status;
    mon_mode_nxt = mon_mode;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START, ST_FILL, ST_DRAIN, ST_SETTLE: begin
        // Fault priority: abort, flow error, timeout, leak
        if (abort) begin
          has_fault  = 1'b1;
          fault_code = STATUS_ABORTED;
        end else if ((state == ST_FILL || state == ST_DRAIN) && flow_error &&
                     !from_start_q) begin
          has_fault  = 1'b1;
          fault_code = STATUS_FLOW_ERR;
        end else if (tmo_zero_c) begin
          has_fault  = 1'b1;
          fault_code = STATUS_TIMEOUT;
        end else if (leak_c) begin
          has_fault  = 1'b1;
          fault_code = STATUS_LEAK;
        end else begin
          case (state)
            ST_START:  state_nxt = level_met ? ST_DONE
                                 : (cmd_q.drain ? ST_DRAIN : ST_FILL);
            ST_FILL,
            ST_DRAIN:  if (level_met) state_nxt = ST_SETTLE;
            default: begin
              if (settle_zero_c)
                state_nxt = settle_ok ? ST_DONE
                          : (cmd_q.drain ? ST_DRAIN : ST_FILL);
            end
          endcase
        end
        if (has_fault) state_nxt = ST_FAULT;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_FAULT: if (clear_fault) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    if (accept)                  status_nxt = STATUS_OK;
    else if (has_fault)          status_nxt = fault_code;
    else if (state_nxt == ST_DONE) status_nxt = STATUS_OK;

    // START takes its mode from the command being accepted
    case (state_nxt)
      ST_START: mon_mode_nxt = ~cmd_drain;
      ST_FILL:  mon_mode_nxt = 1'b1;
      ST_DRAIN: mon_mode_nxt = 1'b0;
      default:  mon_mode_nxt = mon_mode;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cmd_q        <= '0;
      from_start_q <= 1'b0;
      cmd_ready    <= 1'b1;
      fill_valve   <= 1'b0;
      drain_pump   <= 1'b0;
      mon_mode     <= 1'b0;
      mon_reset    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      status       <= STATUS_OK;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q.drain  <= cmd_drain;
        cmd_q.target <= cmd_target;
      end
      from_start_q <= (state == ST_START);
      cmd_ready    <= (state_nxt == ST_IDLE);
      fill_valve   <= (state_nxt == ST_FILL);
      drain_pump   <= (state_nxt == ST_DRAIN);
      mon_mode     <= mon_mode_nxt;
      mon_reset    <= (state_nxt == ST_START);
      busy         <= (state_nxt != ST_IDLE);
      done         <= (state_nxt == ST_DONE);
      fault        <= (state_nxt == ST_FAULT);
      status       <= status_nxt;
    end
  end

endmodule

// File: tb/tb_water_level_controller.sv
// Bench for water_level_controller: directed scenarios with literal
// expectations plus randomized traffic, all outputs compared every cycle
// against a phase-level model of the controller's rules.
module tb_water_level_controller;

  localparam int HYST   = 4;
  localparam int SETTLE = 16;
  localparam int MAXC   = 50;
  localparam int LMAX   = 1023;

  // Model phases
  localparam int P_IDLE = 0, P_START = 1, P_FILL = 2, P_DRAIN = 3,
                 P_SETTLE = 4, P_DONE = 5, P_FAULT = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_drain;
  logic [9:0] cmd_target, water_level_sensor;
  logic       flow_error, abort, clear_fault;
  logic       fill_valve, drain_pump, mon_mode, mon_reset, busy, done, fault;
  logic [2:0] status;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  water_level_controller #(
    .HYST(HYST), .SETTLE_CYCLES(SETTLE), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_drain(cmd_drain),
    .cmd_target(cmd_target), .water_level_sensor(water_level_sensor),
    .flow_error(flow_error), .abort(abort), .clear_fault(clear_fault),
    .fill_valve(fill_valve), .drain_pump(drain_pump), .mon_mode(mon_mode),
    .mon_reset(mon_reset), .busy(busy), .done(done), .fault(fault),
    .status(status)
  );

  // ---------------- behavioural model ----------------
  int m_ph, m_target, m_elapsed, m_settle, m_status;
  bit m_drain, m_mode, m_after_start;

  task automatic model_reset();
    m_ph = P_IDLE; m_target = 0; m_elapsed = 0; m_settle = 0;
    m_status = 0; m_drain = 0; m_mode = 0; m_after_start = 0;
  endtask

  task automatic model_step();
    int s, code, lo, hi, leak_th;
    bit was_start, met, ok;
    s = int'(water_level_sensor);
    code = 0;
    lo = (m_target - HYST < 0) ? 0 : m_target - HYST;
    hi = (m_target + HYST > LMAX) ? LMAX : m_target + HYST;
    leak_th = (m_target - 2 * HYST < 0) ? 0 : m_target - 2 * HYST;
    met = m_drain ? (s <= m_target) : (s >= m_target);
    ok  = m_drain ? (s <= hi) : (s >= lo);
    was_start = (m_ph == P_START);
    case (m_ph)
      P_IDLE: if (cmd_valid) begin
        m_ph = P_START; m_drain = cmd_drain; m_target = int'(cmd_target);
        m_elapsed = 0; m_status = 0;
      end
      P_DONE:  m_ph = P_IDLE;
      P_FAULT: if (clear_fault) m_ph = P_IDLE;
      default: begin
        if (abort) code = 3;
        else if ((m_ph == P_FILL || m_ph == P_DRAIN) && flow_error && !m_after_start) code = 2;
        else if (m_elapsed == MAXC - 1) code = 1;
`ifdef WLC_LEAK_DETECT_EN
        else if (m_ph == P_SETTLE && !m_drain && s < leak_th) code = 4;
`endif
        if (code != 0) begin
          m_ph = P_FAULT; m_status = code;
        end else if (m_ph == P_START) begin
          m_ph = met ? P_DONE : (m_drain ? P_DRAIN : P_FILL);
        end else if (m_ph == P_FILL || m_ph == P_DRAIN) begin
          if (met) begin m_ph = P_SETTLE; m_settle = 0; end
        end else begin
          if (m_settle == SETTLE - 1) m_ph = ok ? P_DONE : (m_drain ? P_DRAIN : P_FILL);
          else m_settle++;
        end
        m_elapsed++;
      end
    endcase
    if (m_ph == P_START || m_ph == P_FILL || m_ph == P_DRAIN) m_mode = !m_drain;
    m_after_start = was_start;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    logic [10:0] exp_v, act_v;
    @(negedge clk);
    if (reset !== 1'b1) begin
      exp_v = {m_ph == P_IDLE, m_ph == P_FILL, m_ph == P_DRAIN, m_mode,
               m_ph == P_START, m_ph != P_IDLE, m_ph == P_DONE, m_ph == P_FAULT,
               3'(m_status)};
      act_v = {cmd_ready, fill_valve, drain_pump, mon_mode, mon_reset,
               busy, done, fault, status};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL cycle_compare t=%0t {rdy,fill,drain,mode,mrst,busy,done,fault,status} got %b required %b",
                 $time, act_v, exp_v);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s t=%0t got %0d required %0d", name, $time, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Accept happens in the first cycle; returns in the START cycle (N+1)
  task automatic send(input bit d, input int t);
    tick();
    cmd_valid = 1'b1; cmd_drain = d; cmd_target = 10'(t);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic clear_it();
    clear_fault = 1'b1; tick(); clear_fault = 1'b0;
  endtask

  initial begin
    int n, s, tgt;
    reset = 1'b1; cmd_valid = 0; cmd_drain = 0; cmd_target = '0;
    water_level_sensor = 10'd100; flow_error = 0; abort = 0; clear_fault = 0;
    #1;
    chk("reset_fill", 16'(fill_valve), 0);
    chk("reset_status", 16'(status), 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    tick();
    chk("idle_ready", 16'(cmd_ready), 1);
    chk("idle_busy", 16'(busy), 0);

    // Abort while idle has no effect
    abort = 1'b1; tick(); tick(); abort = 1'b0;
    chk("idle_abort_busy", 16'(busy), 0);

    // Fill ramp 100 -> 300
    water_level_sensor = 10'd100;
    send(0, 300);
    chk("fill_mon_reset", 16'(mon_reset), 1);
    chk("fill_mon_mode", 16'(mon_mode), 1);
    chk("fill_valve_n1", 16'(fill_valve), 0);
    tick();
    chk("fill_valve_n2", 16'(fill_valve), 1);
    s = 100;
    while (s < 300) begin
      s += 20; water_level_sensor = 10'(s);
      if (s < 300) tick();
    end
    n = 0;
    tick(); n++;
    chk("fill_stop", 16'(fill_valve), 0);
    while (!done && n < 40) begin tick(); n++; end
    chk("fill_done_latency", 16'(n), 17);
    chk("fill_status", 16'(status), 0);
    tick();

    // Drain already at target
    water_level_sensor = 10'd500;
    send(1, 500);
    chk("drain_mon_reset", 16'(mon_reset), 1);
    chk("drain_mon_mode", 16'(mon_mode), 0);
    tick();
    chk("drain_done_n2", 16'(done), 1);
    chk("drain_pump_off", 16'(drain_pump), 0);
    tick();
    chk("drain_ready", 16'(cmd_ready), 1);

    // Refill after settle drop, then done inside tolerance band
    water_level_sensor = 10'd299;
    send(0, 300);
    tick();
    chk("refill_fill_n2", 16'(fill_valve), 1);
    water_level_sensor = 10'd300;
    tick();
    water_level_sensor = 10'd294;
    repeat (16) tick();
    chk("refill_reassert", 16'(fill_valve), 1);
    water_level_sensor = 10'd300;
    tick();
    water_level_sensor = 10'd296;
    repeat (16) tick();
    chk("refill_done", 16'(done), 1);
    chk("refill_status", 16'(status), 0);
    tick();

    // Abort and flow error together: abort wins
    water_level_sensor = 10'd100;
    send(0, 300);
    tick(); tick();
    abort = 1'b1; flow_error = 1'b1;
    tick();
    abort = 1'b0; flow_error = 1'b0;
    chk("abort_fault", 16'(fault), 1);
    chk("abort_status", 16'(status), 3);
    chk("abort_valve", 16'(fill_valve), 0);
    clear_it();
    chk("abort_clear_ready", 16'(cmd_ready), 1);
    chk("abort_status_held", 16'(status), 3);

    // Flow error ignored on first drain cycle, honoured on the next
    water_level_sensor = 10'd600;
    send(1, 300);
    tick();
    flow_error = 1'b1;
    tick();
    chk("flow_first_ignored", 16'(drain_pump), 1);
    tick();
    flow_error = 1'b0;
    chk("flow_fault_status", 16'(status), 2);
    chk("flow_pump_off", 16'(drain_pump), 0);
    clear_it();

    // Timeout
    water_level_sensor = 10'd100;
    send(0, 300);
    repeat (49) tick();
    chk("tmo_not_yet", 16'(fault), 0);
    tick();
    chk("tmo_fault", 16'(fault), 1);
    chk("tmo_status", 16'(status), 1);
    clear_it();

    // Level drop to 290 during fill settle
    water_level_sensor = 10'd299;
    send(0, 300);
    tick();
    water_level_sensor = 10'd300;
    tick();
    water_level_sensor = 10'd290;
    tick();
`ifdef WLC_LEAK_DETECT_EN
    chk("leak_status", 16'(status), 4);
    clear_it();
`else
    chk("leak_no_fault", 16'(fault), 0);
    repeat (15) tick();
    chk("leak_refill", 16'(fill_valve), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    clear_it();
`endif

    // Reset mid-command turns actuators off at once
    water_level_sensor = 10'd100;
    send(0, 300);
    tick();
    reset = 1'b1; #1;
    chk("rst_mid_valve", 16'(fill_valve), 0);
    chk("rst_mid_busy", 16'(busy), 0);
    chk("rst_mid_done", 16'(done), 0);
    tick();
    reset = 1'b0;

    // Randomized traffic
    s = 200;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (fill_valve) s += $urandom_range(12);
      else if (drain_pump) s -= $urandom_range(12);
      else if ($urandom_range(5) == 0) s += $urandom_range(6) - 3;
      if ($urandom_range(99) == 0) s = $urandom_range(1) ? LMAX - $urandom_range(3) : $urandom_range(3);
      if (s < 0) s = 0;
      if (s > LMAX) s = LMAX;
      water_level_sensor = 10'(s);
      case ($urandom_range(9))
        0: tgt = $urandom_range(5);
        1: tgt = LMAX - $urandom_range(5);
        default: tgt = s + $urandom_range(80) - 40;
      endcase
      if (tgt < 0) tgt = 0;
      if (tgt > LMAX) tgt = LMAX;
      cmd_valid   = ($urandom_range(3) == 0);
      cmd_drain   = 1'($urandom_range(1));
      cmd_target  = 10'(tgt);
      abort       = ($urandom_range(199) == 0);
      flow_error  = ($urandom_range(59) == 0);
      clear_fault = fault && ($urandom_range(3) == 0);
    end
    cmd_valid = 0; abort = 0; flow_error = 0; clear_fault = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
